// File: rtl/sid_osc.sv
// rtl/sid_osc.sv - SID voice oscillator: 24-bit phase accumulator, hard sync and 23-bit noise LFSR.
// Define SID_OSC_LFSR_DELAY_EN to shift the LFSR one tick after bit 19 rises instead of on the same tick.
module sid_osc (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic [15:0] freq,
   input  logic        test,
   input  logic        sync,
   input  logic        sync_in,
   output logic [23:0] acc,
   output logic [22:0] lfsr,
   output logic        msb_rise
);

   logic [23:0] acc_q, acc_d, acc_next;
   logic [22:0] lfsr_q, lfsr_d, lfsr_shifted;
   logic        msb_rise_q, msb_rise_d;
   logic        bit19_rise;
`ifdef SID_OSC_LFSR_DELAY_EN
   logic        pend_q, pend_d;
`endif

   assign acc_next     = acc_q + {8'b0, freq};
   assign bit19_rise   = ~acc_q[19] & acc_next[19];
   assign lfsr_shifted = {lfsr_q[21:0], lfsr_q[22] ^ lfsr_q[17]};

   always_comb begin
      acc_d      = acc_q;
      lfsr_d     = lfsr_q;
      msb_rise_d = msb_rise_q;
`ifdef SID_OSC_LFSR_DELAY_EN
      pend_d     = pend_q;
`endif
      if (tick) begin
         if (test) begin
            acc_d      = 24'h000000;
            lfsr_d     = 23'h7FFFFF;
            msb_rise_d = 1'b0;
`ifdef SID_OSC_LFSR_DELAY_EN
            pend_d     = 1'b0;
`endif
         end else if (sync && sync_in) begin
            // A synced tick freezes the noise register; a pending shift waits for a normal tick.
            acc_d      = 24'h000000;
            msb_rise_d = 1'b0;
         end else begin
            acc_d      = acc_next;
            msb_rise_d = ~acc_q[23] & acc_next[23];
`ifdef SID_OSC_LFSR_DELAY_EN
            if (pend_q) begin
               lfsr_d = lfsr_shifted;
            end
            pend_d = bit19_rise;
`else
            if (bit19_rise) begin
               lfsr_d = lfsr_shifted;
            end
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q      <= 24'h000000;
         lfsr_q     <= 23'h7FFFFF;
         msb_rise_q <= 1'b0;
`ifdef SID_OSC_LFSR_DELAY_EN
         pend_q     <= 1'b0;
`endif
      end else begin
         acc_q      <= acc_d;
         lfsr_q     <= lfsr_d;
         msb_rise_q <= msb_rise_d;
`ifdef SID_OSC_LFSR_DELAY_EN
         pend_q     <= pend_d;
`endif
      end
   end

   assign acc      = acc_q;
   assign lfsr     = lfsr_q;
   assign msb_rise = msb_rise_q;

endmodule

// File: tb/tb_sid_osc.sv
// tb/tb_sid_osc.sv - self-checking bench for sid_osc: vector table, directed corner sequences, random vs. model.
module tb_sid_osc;

   logic        clk = 1'b0;
   logic        rst;
   logic        tick;
   logic [15:0] freq;
   logic        test;
   logic        sync;
   logic        sync_in;
   logic [23:0] acc;
   logic [22:0] lfsr;
   logic        msb_rise;

   int errors = 0;
   int checks = 0;

   sid_osc dut (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .freq     (freq),
      .test     (test),
      .sync     (sync),
      .sync_in  (sync_in),
      .acc      (acc),
      .lfsr     (lfsr),
      .msb_rise (msb_rise)
   );

   always #5 clk = ~clk;

   // Reference model: accumulator as a plain integer modulo 2^24.
   int unsigned m_acc;
   logic [22:0] m_lfsr;
   logic        m_msb;
   logic        m_pend;
   logic        m_rose19;

   function automatic logic [22:0] noise_step(input logic [22:0] l);
      logic fb;
      fb = l[22] ^ l[17];
      return {l[21:0], fb};
   endfunction

   task automatic model_reset();
      m_acc    = 0;
      m_lfsr   = 23'h7FFFFF;
      m_msb    = 1'b0;
      m_pend   = 1'b0;
      m_rose19 = 1'b0;
   endtask

   task automatic model_step(input int unsigned f, input logic t, input logic s, input logic si);
      int unsigned nxt;
      nxt = (m_acc + f) % (1 << 24);
      m_rose19 = 1'b0;
      if (t) begin
         m_acc = 0; m_lfsr = 23'h7FFFFF; m_msb = 1'b0; m_pend = 1'b0;
      end else if (s && si) begin
         m_acc = 0; m_msb = 1'b0;
      end else begin
         m_rose19 = (((m_acc >> 19) & 1) == 0) && (((nxt >> 19) & 1) == 1);
         m_msb    = (m_acc < 32'h800000) && (nxt >= 32'h800000);
`ifdef SID_OSC_LFSR_DELAY_EN
         if (m_pend) m_lfsr = noise_step(m_lfsr);
         m_pend = m_rose19;
`else
         if (m_rose19) m_lfsr = noise_step(m_lfsr);
`endif
         m_acc = nxt;
      end
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic check_model(input string name);
      check({name, ".acc"},  {8'b0, acc},       m_acc);
      check({name, ".lfsr"}, {9'b0, lfsr},      {9'b0, m_lfsr});
      check({name, ".msb"},  {31'b0, msb_rise}, {31'b0, m_msb});
   endtask

   // One tick pulse with the given inputs, followed by gap idle clocks; outputs sampled 1 time unit after the edge.
   task automatic tick_once(input logic [15:0] f, input logic t, input logic s, input logic si, input int gap);
      @(negedge clk);
      freq = f; test = t; sync = s; sync_in = si; tick = 1'b1;
      @(posedge clk);
      model_step(f, t, s, si);
      #1;
      tick = 1'b0;
      repeat (gap) @(posedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      tick = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      tick = 1'b0;
   endtask

   task automatic build_123456();
      tick_once(16'h0000, 1'b1, 1'b0, 1'b0, 0);
      tick_once(16'h3456, 1'b0, 1'b0, 1'b0, 0);
      for (int i = 0; i < 36; i++) tick_once(16'h8000, 1'b0, 1'b0, 1'b0, 0);
   endtask

   typedef struct {
      logic [15:0] freq;
      logic        test;
      logic        sync;
      logic        sync_in;
      logic [23:0] e_acc;
      logic [22:0] e_lfsr;
      logic        e_msb;
   } vec_t;

   vec_t tbl [8];

   initial begin
      logic [23:0] held_acc;
      logic [22:0] held_lfsr;
      logic        held_msb;
      int n;

      tbl[0] = '{16'h1000, 1'b0, 1'b0, 1'b0, 24'h001000, 23'h7FFFFF, 1'b0};
      tbl[1] = '{16'h0000, 1'b0, 1'b0, 1'b0, 24'h001000, 23'h7FFFFF, 1'b0};
      tbl[2] = '{16'hFFFF, 1'b0, 1'b0, 1'b0, 24'h010FFF, 23'h7FFFFF, 1'b0};
      tbl[3] = '{16'h0001, 1'b0, 1'b1, 1'b0, 24'h011000, 23'h7FFFFF, 1'b0};
      tbl[4] = '{16'h0005, 1'b0, 1'b1, 1'b1, 24'h000000, 23'h7FFFFF, 1'b0};
      tbl[5] = '{16'h0007, 1'b0, 1'b0, 1'b1, 24'h000007, 23'h7FFFFF, 1'b0};
      tbl[6] = '{16'h1234, 1'b1, 1'b0, 1'b0, 24'h000000, 23'h7FFFFF, 1'b0};
      tbl[7] = '{16'h1234, 1'b1, 1'b1, 1'b1, 24'h000000, 23'h7FFFFF, 1'b0};

      rst = 1'b1; tick = 1'b0; freq = 16'h0; test = 1'b0; sync = 1'b0; sync_in = 1'b0;
      do_reset();
      check("reset.acc",  {8'b0, acc},       32'h0);
      check("reset.lfsr", {9'b0, lfsr},      32'h7FFFFF);
      check("reset.msb",  {31'b0, msb_rise}, 32'h0);

      for (int i = 0; i < 8; i++) begin
         tick_once(tbl[i].freq, tbl[i].test, tbl[i].sync, tbl[i].sync_in, 1);
         check($sformatf("vec%0d.acc", i),  {8'b0, acc},       {8'b0, tbl[i].e_acc});
         check($sformatf("vec%0d.lfsr", i), {9'b0, lfsr},      {9'b0, tbl[i].e_lfsr});
         check($sformatf("vec%0d.msb", i),  {31'b0, msb_rise}, {31'b0, tbl[i].e_msb});
      end

      // Long sweep at freq 0x1000, one tick every 4 clocks.
      do_reset();
      for (int k = 1; k <= 4096; k++) begin
         tick_once(16'h1000, 1'b0, 1'b0, 1'b0, 3);
         if (k == 1)   check("sweep.t1.acc", {8'b0, acc}, 32'h001000);
         if (k == 127) check("sweep.t127.lfsr", {9'b0, lfsr}, 32'h7FFFFF);
`ifdef SID_OSC_LFSR_DELAY_EN
         if (k == 128) check("sweep.t128.lfsr", {9'b0, lfsr}, 32'h7FFFFF);
         if (k == 129) check("sweep.t129.lfsr", {9'b0, lfsr}, 32'h7FFFFE);
`else
         if (k == 128) check("sweep.t128.lfsr", {9'b0, lfsr}, 32'h7FFFFE);
         if (k == 129) check("sweep.t129.lfsr", {9'b0, lfsr}, 32'h7FFFFE);
`endif
         if (k == 2047) check("sweep.t2047.msb", {31'b0, msb_rise}, 32'h0);
         if (k == 2048) begin
            check("sweep.t2048.acc", {8'b0, acc},       32'h800000);
            check("sweep.t2048.msb", {31'b0, msb_rise}, 32'h1);
         end
         if (k == 2049) check("sweep.t2049.msb", {31'b0, msb_rise}, 32'h0);
         if (k == 4096) check("sweep.t4096.acc", {8'b0, acc},       32'h0);
      end
      check_model("sweep.end");

      // Test tick while a bit19 rise is fresh (pending shift when delayed).
      do_reset();
      for (int i = 0; i < 50; i++) tick_once(16'hFFFF, 1'b0, 1'b0, 1'b0, 0);
      n = 0;
      m_rose19 = 1'b0;
      while (!m_rose19 && n < 100) begin
         tick_once(16'hFFFF, 1'b0, 1'b0, 1'b0, 0);
         n++;
      end
      check("pend.found", {31'b0, m_rose19}, 32'h1);
      tick_once(16'hFFFF, 1'b1, 1'b0, 1'b0, 0);
      check("pend.test.acc",  {8'b0, acc},       32'h0);
      check("pend.test.lfsr", {9'b0, lfsr},      32'h7FFFFF);
      check("pend.test.msb",  {31'b0, msb_rise}, 32'h0);
      for (int i = 0; i < 3; i++) tick_once(16'h0000, 1'b0, 1'b0, 1'b0, 0);
      check("pend.after.lfsr", {9'b0, lfsr}, 32'h7FFFFF);
      check("pend.after.acc",  {8'b0, acc},  32'h0);

      // Hard sync versus no sync from the same accumulator value.
      build_123456();
      check("sync.pre.acc", {8'b0, acc}, 32'h123456);
      tick_once(16'h0100, 1'b0, 1'b1, 1'b1, 0);
      check("sync.on.acc", {8'b0, acc}, 32'h0);
      check_model("sync.on");
      build_123456();
      tick_once(16'h0100, 1'b0, 1'b0, 1'b1, 0);
      check("sync.off.acc", {8'b0, acc}, 32'h123556);

      // Idle hold, then asynchronous reset between edges.
      held_acc = acc; held_lfsr = lfsr; held_msb = msb_rise;
      @(negedge clk);
      freq = 16'hFFFF; tick = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      check("hold.acc",  {8'b0, acc},       {8'b0, held_acc});
      check("hold.lfsr", {9'b0, lfsr},      {9'b0, held_lfsr});
      check("hold.msb",  {31'b0, msb_rise}, {31'b0, held_msb});
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async.acc",  {8'b0, acc},       32'h0);
      check("async.lfsr", {9'b0, lfsr},      32'h7FFFFF);
      check("async.msb",  {31'b0, msb_rise}, 32'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;

      // Randomized ticks against the model, with occasional mid-run resets.
      for (int i = 0; i < 400; i++) begin
         logic [15:0] f;
         if ($urandom_range(0, 49) == 0) do_reset();
         f = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom);
         tick_once(f, $urandom_range(0, 15) == 0, 1'($urandom), 1'($urandom), $urandom_range(0, 2));
         check_model($sformatf("rand%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
